ulbf_slave_rx: RTL and testbench



---
 rtl/ulbf_slave_pkg.sv | 18 +
 rtl/ulbf_slave_rxram.sv | 30 +++
 rtl/ulbf_slave_rx.sv | 130 +++++++++++++
 tb/tb_ulbf_slave_rx.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/ulbf_slave_pkg.sv
// rtl/ulbf_slave_pkg.sv - shared constants and state codes for the ULBF slave receive path
// Purpose: state encoding reported on current_state, the stream/RAM word width
//          and the width of the word counter that crosses to the bus domain.
// Ports:   none (package).
package ulbf_slave_pkg;

  localparam int DATA_W      = 64;
  localparam int RXRAM_CNT_W = 16;

  // Codes are visible on current_state, so they are fixed 4-bit values.
  typedef enum logic [3:0] {
    IDLE = 4'd0,
    RECV = 4'd1,
    DONE = 4'd2,
    FULL = 4'd3
  } rx_state_t;

endpackage

// File: rtl/ulbf_slave_rxram.sv
// rtl/ulbf_slave_rxram.sv - capture RAM, 1 write / 1 registered read port, read-first
// Purpose: holds the captured stream words; port B reads are registered and
//          return the old contents when the same address is written that cycle.
// Ports:   clk           - clock shared by both ports
//          we/waddr/wdata - write port
//          re/raddr/rdata - read port, rdata updates only when re=1
module ulbf_slave_rxram
  import ulbf_slave_pkg::DATA_W;
#(
  parameter int W  = DATA_W,
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [2**AW];

  // Both accesses in one block: the read samples mem before the write lands.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/ulbf_slave_rx.sv
// rtl/ulbf_slave_rx.sv - AXI4-Stream capture engine of the ULBF slave
// Purpose: captures niter tlast-delimited iterations of 64-bit beats into the
//          capture RAM, reports progress/completion and serves read-back.
// Ports:   s_axis_clk, slave_rst      - clock, async active-high reset/restart
//          s_axis_tdata/tvalid/tready/tlast - input stream
//          niter                      - iterations to capture, 0 = disabled
//          rxdone, overflow           - completion / RAM-full flags
//          current_state              - FSM state code
//          rxram_counter              - words written since reset
//          addrb/enb/web/doutb        - read-back port B (web ignored)
module ulbf_slave_rx
  import ulbf_slave_pkg::rx_state_t;
  import ulbf_slave_pkg::IDLE;
  import ulbf_slave_pkg::RECV;
  import ulbf_slave_pkg::DONE;
  import ulbf_slave_pkg::FULL;
  import ulbf_slave_pkg::RXRAM_CNT_W;
#(
  parameter int DATA_W = 64,
  parameter int RAM_AW = 12,
  parameter int ITER_W = 12
) (
  input  logic                   s_axis_clk,
  input  logic                   slave_rst,
  input  logic [DATA_W-1:0]      s_axis_tdata,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic                   s_axis_tlast,
  input  logic [ITER_W-1:0]      niter,
  output logic                   rxdone,
  output logic [3:0]             current_state,
  output logic [RXRAM_CNT_W-1:0] rxram_counter,
  output logic                   overflow,
  input  logic [15:0]            addrb,
  input  logic                   enb,
  input  logic                   web,
  output logic [DATA_W-1:0]      doutb
);

  rx_state_t         state;
  logic [ITER_W-1:0] niter_lat;
  logic [ITER_W-1:0] iter_cnt;
  logic [ITER_W-1:0] iter_next;
  logic [RAM_AW-1:0] wr_addr;
  logic              accept;
  logic              final_beat;

  assign accept        = s_axis_tvalid & s_axis_tready;
  assign iter_next     = iter_cnt + 1'b1;
  assign final_beat    = s_axis_tlast && (iter_next == niter_lat);
  assign current_state = state;

  always_ff @(posedge s_axis_clk or posedge slave_rst) begin
    if (slave_rst) begin
      state         <= IDLE;
      s_axis_tready <= 1'b0;
      rxdone        <= 1'b0;
      overflow      <= 1'b0;
      rxram_counter <= '0;
      iter_cnt      <= '0;
      wr_addr       <= '0;
      niter_lat     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (niter != '0) begin
            niter_lat     <= niter;
            state         <= RECV;
            s_axis_tready <= 1'b1;
          end
        end
        RECV: begin
          if (accept) begin
            wr_addr       <= wr_addr + 1'b1;
            rxram_counter <= rxram_counter + 1'b1;
            if (s_axis_tlast) iter_cnt <= iter_next;
            // Completion takes priority over the RAM filling on the same beat.
            if (final_beat) begin
              state         <= DONE;
              s_axis_tready <= 1'b0;
              rxdone        <= 1'b1;
            end else if (&wr_addr) begin
              state         <= FULL;
              s_axis_tready <= 1'b0;
              rxdone        <= 1'b1;
              overflow      <= 1'b1;
            end
          end
        end
        default: ; // DONE and FULL are terminal until reset
      endcase
    end
  end

  // Port B: out-of-range addresses and the post-reset state read as zero.
  logic              rd_valid;
  logic              rd_oob;
  logic              addr_oob;
  logic [DATA_W-1:0] ram_dout;
  logic              unused_web;

  assign unused_web = web;
  assign addr_oob   = (addrb >> RAM_AW) != 16'd0;

  always_ff @(posedge s_axis_clk or posedge slave_rst) begin
    if (slave_rst) begin
      rd_valid <= 1'b0;
      rd_oob   <= 1'b0;
    end else if (enb) begin
      rd_valid <= 1'b1;
      rd_oob   <= addr_oob;
    end
  end

  assign doutb = (rd_valid && !rd_oob) ? ram_dout : '0;

  ulbf_slave_rxram #(
    .W  (DATA_W),
    .AW (RAM_AW)
  ) u_rxram (
    .clk   (s_axis_clk),
    .we    (accept),
    .waddr (wr_addr),
    .wdata (s_axis_tdata),
    .re    (enb),
    .raddr (addrb[RAM_AW-1:0]),
    .rdata (ram_dout)
  );

endmodule

// File: tb/tb_ulbf_slave_rx.sv
// tb/tb_ulbf_slave_rx.sv - directed self-checking bench for ulbf_slave_rx
module tb_ulbf_slave_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] tdata = '0;
  logic        tvalid = 1'b0;
  logic        tlast = 1'b0;
  logic [11:0] niter = '0;
  logic [15:0] addrb = '0;
  logic        enb = 1'b0;
  logic        web = 1'b0;

  logic        tready12, rxdone12, overflow12;
  logic [3:0]  state12;
  logic [15:0] cnt12;
  logic [63:0] doutb12;
  logic        tready4, rxdone4, overflow4;
  logic [3:0]  state4;
  logic [15:0] cnt4;
  logic [63:0] doutb4;

  int vec  = 0;
  int errs = 0;
  int acc;

  always #5 clk = ~clk;

  ulbf_slave_rx #(.DATA_W(64), .RAM_AW(12), .ITER_W(12)) dut (
    .s_axis_clk(clk), .slave_rst(rst),
    .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(tready12),
    .s_axis_tlast(tlast), .niter(niter), .rxdone(rxdone12),
    .current_state(state12), .rxram_counter(cnt12), .overflow(overflow12),
    .addrb(addrb), .enb(enb), .web(web), .doutb(doutb12)
  );

  ulbf_slave_rx #(.DATA_W(64), .RAM_AW(4), .ITER_W(12)) dut4 (
    .s_axis_clk(clk), .slave_rst(rst),
    .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(tready4),
    .s_axis_tlast(tlast), .niter(niter), .rxdone(rxdone4),
    .current_state(state4), .rxram_counter(cnt4), .overflow(overflow4),
    .addrb(addrb), .enb(enb), .web(web), .doutb(doutb4)
  );

  function automatic logic [63:0] dat(input int base, input int i);
    return {32'(base) ^ 32'hC0DE_0000, 32'(i) ^ 32'h5A5A_0000};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Offers beats until n are accepted or the cycle budget runs out; tlast on
  // every period-th beat (period 0 = never).
  task automatic send(input int n, input int period, input bit sel4,
                      input int base, input int budget, output int accepted);
    logic tr;
    accepted = 0;
    for (int c = 0; c < budget && accepted < n; c++) begin
      tvalid = 1'b1;
      tdata  = dat(base, accepted);
      tlast  = (period != 0) && (((accepted + 1) % period) == 0);
      tr     = sel4 ? tready4 : tready12;
      @(posedge clk); #1;
      if (tr) begin
        accepted++;
        chk("rxram_counter_step", sel4 ? 64'(cnt4) : 64'(cnt12), 64'(accepted));
      end
    end
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tready",   64'(tready12),   64'd0);
    chk("rst_rxdone",   64'(rxdone12),   64'd0);
    chk("rst_overflow", 64'(overflow12), 64'd0);
    chk("rst_state",    64'(state12),    64'd0);
    chk("rst_counter",  64'(cnt12),      64'd0);
    chk("rst_doutb",    doutb12,         64'd0);
    chk("rst_state4",   64'(state4),     64'd0);

    // niter=2, tlast on beats 4 and 8, ninth beat must stall
    rst   = 1'b0;
    niter = 12'd2;
    send(9, 4, 1'b0, 1, 20, acc);
    chk("t1_accepted", 64'(acc),      64'd8);
    chk("t1_rxdone",   64'(rxdone12), 64'd1);
    chk("t1_state",    64'(state12),  64'd2);
    chk("t1_tready",   64'(tready12), 64'd0);
    chk("t1_counter",  64'(cnt12),    64'd8);

    // Read-back of the capture
    enb = 1'b1;
    for (int a = 0; a < 8; a++) begin
      addrb = 16'(a);
      @(posedge clk); #1;
      chk("t2_read", doutb12, dat(1, a));
    end
    addrb = 16'h1000;
    @(posedge clk); #1;
    chk("t2_oob", doutb12, 64'd0);
    web = 1'b1; addrb = 16'd2;
    @(posedge clk); #1;
    web = 1'b0;
    @(posedge clk); #1;
    chk("t2_web_ignored", doutb12, dat(1, 2));
    enb = 1'b0; addrb = 16'd5;
    @(posedge clk); #1;
    chk("t2_hold", doutb12, dat(1, 2));

    // RAM_AW=4, no tlast: RAM fills
    do_reset();
    niter = 12'd1;
    send(20, 0, 1'b1, 2, 40, acc);
    chk("t3_accepted", 64'(acc),       64'd16);
    chk("t3_state",    64'(state4),    64'd3);
    chk("t3_overflow", 64'(overflow4), 64'd1);
    chk("t3_rxdone",   64'(rxdone4),   64'd1);
    chk("t3_counter",  64'(cnt4),      64'd16);

    // RAM_AW=4, final tlast on the last address: DONE wins
    do_reset();
    niter = 12'd1;
    send(16, 16, 1'b1, 3, 30, acc);
    chk("t4_accepted", 64'(acc),       64'd16);
    chk("t4_state",    64'(state4),    64'd2);
    chk("t4_overflow", 64'(overflow4), 64'd0);
    chk("t4_counter",  64'(cnt4),      64'd16);

    // niter=0 keeps capture disabled
    do_reset();
    niter  = 12'd0;
    tvalid = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    chk("t5_idle_tready", 64'(tready12), 64'd0);
    chk("t5_idle_state",  64'(state12),  64'd0);
    chk("t5_idle_count",  64'(cnt12),    64'd0);
    niter = 12'd1;
    @(posedge clk); #1;
    chk("t5_recv_state",  64'(state12),  64'd1);
    chk("t5_recv_tready", 64'(tready12), 64'd1);
    tvalid = 1'b0;

    // Reset mid-stream, then a fresh 3-beat capture
    do_reset();
    niter = 12'd2;
    send(5, 0, 1'b0, 4, 20, acc);
    chk("t6_pre_accepted", 64'(acc), 64'd5);
    tvalid = 1'b1;
    tdata  = dat(4, 5);
    #3;
    rst = 1'b1;
    #1;
    chk("t6_async_tready", 64'(tready12), 64'd0);
    tvalid = 1'b0;
    @(posedge clk); #1;
    rst   = 1'b0;
    niter = 12'd1;
    send(3, 3, 1'b0, 5, 20, acc);
    chk("t6_accepted", 64'(acc),      64'd3);
    chk("t6_counter",  64'(cnt12),    64'd3);
    chk("t6_rxdone",   64'(rxdone12), 64'd1);
    chk("t6_state",    64'(state12),  64'd2);
    enb = 1'b1;
    for (int a = 0; a < 4; a++) begin
      addrb = 16'(a);
      @(posedge clk); #1;
      // Address 3 was not rewritten and keeps the pre-reset capture.
      chk("t6_read", doutb12, (a < 3) ? dat(5, a) : dat(4, 3));
    end
    enb = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
